// File: rtl/flash_read_arbiter.sv
// Two-port round-robin arbiter sharing one SPI flash.
// Each grant runs a single-bit READ (0x03) and returns one 32-bit word.
module flash_read_arbiter #(
    parameter int CLK_DIV  = 1,
    parameter int CSB_HIGH = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req0,
    input  logic [23:0] addr0,
    output logic        ack0,
    input  logic        req1,
    input  logic [23:0] addr1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DESEL
    } state_t;

    localparam logic [3:0] DIV_LD = 4'(CLK_DIV - 1);
    localparam logic [3:0] CSB_LD = 4'(CSB_HIGH - 1);

    state_t      r_state, w_state;
    logic [3:0]  r_div, w_div;
    logic [5:0]  r_bit, w_bit;
    logic        r_gnt, w_gnt;
    logic        r_last, w_last;
    logic [31:0] r_sh, w_sh;
    logic [31:0] r_rx, w_rx;
    logic [31:0] r_rdata, w_rdata;
    logic        r_ack0, w_ack0;
    logic        r_ack1, w_ack1;
    logic        r_busy, w_busy;
    logic        r_csb, w_csb;
    logic        r_clk, w_clk;
    logic        r_io0, w_io0;

    logic        w_div_zero;
    logic        w_pick1;
    logic [23:0] w_addr;
    logic [31:0] w_cmd;

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign w_pick1    = req1 & (~req0 | ~r_last);
    assign w_addr     = w_pick1 ? addr1 : addr0;
    assign w_cmd      = {8'h03, w_addr & 24'hFFFFFC};
    assign w_div_zero = (r_div == 4'd0);

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_gnt   = r_gnt;
        w_last  = r_last;
        w_sh    = r_sh;
        w_rx    = r_rx;
        w_rdata = r_rdata;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_busy  = r_busy;
        w_csb   = r_csb;
        w_clk   = r_clk;
        w_io0   = r_io0;
        unique case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_gnt   = w_pick1;
                    w_sh    = w_cmd;
                    w_io0   = w_cmd[31];
                    w_csb   = 1'b0;
                    w_busy  = 1'b1;
                    w_div   = DIV_LD;
                    w_bit   = 6'd0;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_div_zero) begin
                    w_div   = DIV_LD;
                    w_state = S_SHIFT;
                end else begin
                    w_div = r_div - 4'd1;
                end
            end
            S_SHIFT: begin
                if (w_div_zero) begin
                    w_div = DIV_LD;
                    if (!r_clk) begin
                        w_clk = 1'b1;
                    end else begin
                        // Falling edge: sample MISO, advance MOSI.
                        w_clk = 1'b0;
                        w_sh  = {r_sh[30:0], 1'b0};
                        w_io0 = r_sh[30];
                        if (r_bit[5]) begin
                            w_rx = {r_rx[30:0], flash_io1};
                        end
                        w_bit = r_bit + 6'd1;
                        if (r_bit == 6'd63) begin
                            w_state = S_HOLD;
                        end
                    end
                end else begin
                    w_div = r_div - 4'd1;
                end
            end
            S_HOLD: begin
                if (w_div_zero) begin
                    w_csb   = 1'b1;
                    w_div   = CSB_LD;
                    w_rdata = {r_rx[7:0], r_rx[15:8],
                               r_rx[23:16], r_rx[31:24]};
                    w_ack0  = ~r_gnt;
                    w_ack1  = r_gnt;
                    w_last  = r_gnt;
                    w_state = S_DESEL;
                end else begin
                    w_div = r_div - 4'd1;
                end
            end
            S_DESEL: begin
                if (w_div_zero) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_div = r_div - 4'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
            r_div   <= 4'd0;
            r_bit   <= 6'd0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_sh    <= 32'd0;
            r_rx    <= 32'd0;
            r_rdata <= 32'd0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
            r_csb   <= 1'b1;
            r_clk   <= 1'b0;
            r_io0   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_gnt   <= w_gnt;
            r_last  <= w_last;
            r_sh    <= w_sh;
            r_rx    <= w_rx;
            r_rdata <= w_rdata;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
            r_busy  <= w_busy;
            r_csb   <= w_csb;
            r_clk   <= w_clk;
            r_io0   <= w_io0;
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign flash_csb = r_csb;
    assign flash_clk = r_clk;
    assign flash_io0 = r_io0;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: two instances (H=1, H=2),
// each with a behavioural SPI flash answering READ commands.
module tb_flash_read_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req0, a_req1, a_ack0, a_ack1;
    logic [23:0] a_addr0, a_addr1;
    logic [31:0] a_rdata;
    logic        a_busy, a_csb, a_sclk, a_io0, a_io1;
    logic        b_req0, b_req1, b_ack0, b_ack1;
    logic [23:0] b_addr0, b_addr1;
    logic [31:0] b_rdata;
    logic        b_busy, b_csb, b_sclk, b_io0, b_io1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int unexp = 0;
    int both = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic [31:0] cmd;
        int          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    flash_read_arbiter #(.CLK_DIV(1), .CSB_HIGH(4)) dut_a (
        .clock(clk), .resetb(rst_n),
        .req0(a_req0), .addr0(a_addr0), .ack0(a_ack0),
        .req1(a_req1), .addr1(a_addr1), .ack1(a_ack1),
        .rdata(a_rdata), .busy(a_busy),
        .flash_csb(a_csb), .flash_clk(a_sclk),
        .flash_io0(a_io0), .flash_io1(a_io1)
    );

    flash_read_arbiter #(.CLK_DIV(2), .CSB_HIGH(4)) dut_b (
        .clock(clk), .resetb(rst_n),
        .req0(b_req0), .addr0(b_addr0), .ack0(b_ack0),
        .req1(b_req1), .addr1(b_addr1), .ack1(b_ack1),
        .rdata(b_rdata), .busy(b_busy),
        .flash_csb(b_csb), .flash_clk(b_sclk),
        .flash_io0(b_io0), .flash_io1(b_io1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Flash model A
    int          fa_cnt = 0;
    logic [31:0] fa_cmd = 32'd0;
    always @(negedge a_csb) fa_cnt = 0;
    always @(posedge a_sclk) if (!a_csb) begin
        if (fa_cnt < 32) fa_cmd = {fa_cmd[30:0], a_io0};
        fa_cnt++;
    end
    always @(negedge a_sclk) if (!a_csb && fa_cnt >= 32 && fa_cnt < 64) begin
        logic [7:0] byt;
        int k;
        k = fa_cnt - 32;
        byt = fbyte(fa_cmd[23:0] + 24'(k / 8));
        a_io1 = byt[7 - (k % 8)];
    end

    // Flash model B
    int          fb_cnt = 0;
    logic [31:0] fb_cmd = 32'd0;
    always @(negedge b_csb) fb_cnt = 0;
    always @(posedge b_sclk) if (!b_csb) begin
        if (fb_cnt < 32) fb_cmd = {fb_cmd[30:0], b_io0};
        fb_cnt++;
    end
    always @(negedge b_sclk) if (!b_csb && fb_cnt >= 32 && fb_cnt < 64) begin
        logic [7:0] byt;
        int k;
        k = fb_cnt - 32;
        byt = fbyte(fb_cmd[23:0] + 24'(k / 8));
        b_io1 = byt[7 - (k % 8)];
    end

    // Monitor A
    int   ga = 0;
    logic a_busy_d = 1'b0;
    logic a_io0_d = 1'b0;
    int   a_viol = 0;
    int   gap_run = 0;
    int   gap_min = 1000;
    bit   gap_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (a_busy && !a_busy_d) ga = cyc;
            if (a_ack0 && a_ack1) both++;
            if (a_ack0 || a_ack1) begin
                if (qa.size() == 0) begin
                    unexp++;
                end else begin
                    e = qa.pop_front();
                    chk("a_port", 32'(a_ack1), 32'(e.port));
                    chk("a_rdata", a_rdata, e.data);
                    chk("a_cmd", fa_cmd, e.cmd);
                    chk("a_latency", 32'(cyc - ga), 32'(e.lat));
                end
            end
        end
        a_busy_d = a_busy;
        if (a_io0 !== a_io0_d && a_sclk) a_viol++;
        a_io0_d = a_io0;
        if (a_csb) begin
            gap_run++;
        end else begin
            if (gap_seen && gap_run > 0 && gap_run < gap_min) gap_min = gap_run;
            gap_seen = 1'b1;
            gap_run = 0;
        end
    end

    // Monitor B
    int   gb = 0;
    logic b_busy_d = 1'b0;
    logic b_io0_d = 1'b0;
    logic b_sclk_d = 1'b0;
    int   b_viol = 0;
    int   b_rise = 0;
    int   b_per = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (b_busy && !b_busy_d) gb = cyc;
            if (b_ack0 && b_ack1) both++;
            if (b_ack0 || b_ack1) begin
                if (qb.size() == 0) begin
                    unexp++;
                end else begin
                    e = qb.pop_front();
                    chk("b_port", 32'(b_ack1), 32'(e.port));
                    chk("b_rdata", b_rdata, e.data);
                    chk("b_cmd", fb_cmd, e.cmd);
                    chk("b_latency", 32'(cyc - gb), 32'(e.lat));
                end
            end
            if (b_sclk && !b_sclk_d) begin
                if (b_rise > 0) b_per = cyc - b_rise;
                b_rise = cyc;
            end
        end
        b_busy_d = b_busy;
        b_sclk_d = b_sclk;
        if (b_io0 !== b_io0_d && b_sclk) b_viol++;
        b_io0_d = b_io0;
    end

    function automatic bit cond(input int what);
        case (what)
            0:       return a_ack0 || a_ack1;
            1:       return a_busy;
            2:       return !a_busy;
            default: return b_ack0 || b_ack1;
        endcase
    endfunction

    task automatic wait_for(input int what, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(what) && n < 2000);
        if (!cond(what)) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=none required=event", name);
        end
    endtask

    task automatic push_a(input logic p, input logic [31:0] d,
                          input logic [31:0] c, input int l);
        exp_t e;
        e.port = p; e.data = d; e.cmd = c; e.lat = l;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic p, input logic [31:0] d,
                          input logic [31:0] c, input int l);
        exp_t e;
        e.port = p; e.data = d; e.cmd = c; e.lat = l;
        qb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req0 = 0; a_req1 = 0; a_addr0 = 0; a_addr1 = 0; a_io1 = 0;
        b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0; b_io1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_csb", 32'(a_csb), 32'd1);
        chk("rst_sclk", 32'(a_sclk), 32'd0);
        chk("rst_io0", 32'(a_io0), 32'd0);
        chk("rst_ack", 32'({a_ack1, a_ack0}), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_b_csb", 32'(b_csb), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: port 0 basic read
        push_a(1'b0, 32'h44332211, 32'h03000100, 130);
        a_addr0 = 24'h000100; a_req0 = 1'b1;
        wait_for(0, "t1_ack");
        a_req0 = 1'b0;

        // 2: port 1, low address bits ignored
        push_a(1'b1, 32'h44332211, 32'h03000100, 130);
        a_addr1 = 24'h000103; a_req1 = 1'b1;
        wait_for(0, "t2_ack");
        a_req1 = 1'b0;
        @(negedge clk);

        // 3: both held, alternating grants
        push_a(1'b0, 32'hE6E7E4E5, 32'h03000040, 130);
        push_a(1'b1, 32'h26272425, 32'h03000080, 130);
        push_a(1'b0, 32'hE6E7E4E5, 32'h03000040, 130);
        push_a(1'b1, 32'h26272425, 32'h03000080, 130);
        a_addr0 = 24'h000040; a_addr1 = 24'h000080;
        a_req0 = 1'b1; a_req1 = 1'b1;
        for (int i = 0; i < 4; i++) wait_for(0, "t3_ack");
        a_req0 = 1'b0; a_req1 = 1'b0;

        // 4: H=2 instance, including top-of-array address
        push_b(1'b0, 32'h5A5B5859, 32'h03FFFFFC, 260);
        b_addr0 = 24'hFFFFFC; b_req0 = 1'b1;
        wait_for(3, "t4_ack0");
        b_req0 = 1'b0;
        push_b(1'b1, 32'hE6E7E4E5, 32'h03000040, 260);
        b_addr1 = 24'h000040; b_req1 = 1'b1;
        wait_for(3, "t4_ack1");
        b_req1 = 1'b0;
        repeat (10) @(negedge clk);

        // 5: reset mid-transaction
        a_addr0 = 24'h000080; a_req0 = 1'b1;
        wait_for(1, "t5_grant");
        repeat (49) @(negedge clk);
        a_req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_csb", 32'(a_csb), 32'd1);
        chk("t5_sclk", 32'(a_sclk), 32'd0);
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_ack", 32'({a_ack1, a_ack0}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_a(1'b0, 32'h44332211, 32'h03000100, 130);
        a_addr0 = 24'h000100; a_req0 = 1'b1;
        wait_for(0, "t5_ack");
        a_req0 = 1'b0;
        @(negedge clk);

        // 6: request dropped mid-transaction still completes
        push_a(1'b0, 32'hE6E7E4E5, 32'h03000040, 130);
        push_a(1'b1, 32'h26272425, 32'h03000080, 130);
        a_addr0 = 24'h000040; a_req0 = 1'b1;
        wait_for(1, "t6_grant");
        repeat (10) @(negedge clk);
        a_req0 = 1'b0;
        a_addr1 = 24'h000080; a_req1 = 1'b1;
        wait_for(0, "t6_ack0");
        wait_for(2, "t6_idle");
        wait_for(0, "t6_ack1");
        a_req1 = 1'b0;

        repeat (20) @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        chk("unexpected_acks", 32'(unexp), 32'd0);
        chk("both_acks", 32'(both), 32'd0);
        chk("a_io0_high_change", 32'(a_viol), 32'd0);
        chk("b_io0_high_change", 32'(b_viol), 32'd0);
        chk("csb_gap_ge4", 32'(gap_min >= 4), 32'd1);
        chk("b_sclk_period", 32'(b_per), 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
